// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: sends a WIDTH-bit word LSB first,
// one bit per clk, with a load/ready handshake and a done pulse.
module piso_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             last;
   logic             accept;

   assign last   = (state == SHIFT) && (cnt == LAST_CNT);
   assign accept = load && ((state == IDLE) || last);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last && !accept) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: a reload on the last bit restarts the word with no gap.
   always_comb begin
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      if (accept) begin
         shreg_nxt = din;
         cnt_nxt   = '0;
      end else if (state == SHIFT) begin
         if (!last) begin
            shreg_nxt = shreg >> 1;
            cnt_nxt   = cnt + CW'(1);
         end else begin
            cnt_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
         done  <= last;
      end
   end

   always_comb begin
      ready   = (state == IDLE) || last;
      x_valid = (state == SHIFT);
      x_out   = (state == SHIFT) ? shreg[0] : 1'b0;
   end

endmodule
